branch_predict_unit: RTL
========================

Name: branch_predict_unit

Overview:
- Next-PC generation stage that sits directly upstream of the instruction fetch unit.
- Drives the fetch unit's next_pc and pc_write inputs.
- Predicts the next fetch address from the current PC using a direct-mapped branch target buffer (BTB) with 2-bit saturating counters.
- Accepts branch resolution from EX: trains the tables and, on misprediction, redirects fetch and raises flush.

Parameters:
- IDX_BITS, 4: log2 of BTB entries (16 entries).
- RESET_CTR, 2'b01: counter value loaded into every entry at reset (weakly not-taken).

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; sampled on rising edge of clock.
- pc  in  32  current fetch PC (fetch unit PC register).
- stall  in  1  hazard-unit request to hold fetch.
- next_pc  out  32  address for fetch unit to load.
- pc_write  out  1  PC load enable to fetch unit.
- pred_taken  out  1  prediction for pc; pipelined alongside the instruction.
- pred_target  out  32  predicted target for pc; pipelined alongside the instruction.
- ex_valid  in  1  resolution valid this cycle.
- ex_is_branch  in  1  resolved instruction is a branch or jump.
- ex_pc  in  32  PC of the resolved instruction.
- ex_taken  in  1  actual direction.
- ex_target  in  32  actual taken target.
- ex_pred_taken  in  1  pred_taken carried down the pipe for ex_pc.
- ex_pred_target  in  32  pred_target carried down the pipe for ex_pc.
- flush  out  1  mispredict; squash IF/ID and ID/EX.
- branch_count  out  32  resolved branches since reset.
- mispredict_count  out  32  mispredictions since reset.

Behaviour:
- Entry fields: valid, tag = pc[31:IDX_BITS+2], target[31:0], ctr[1:0].
- Index: pc[IDX_BITS+1:2]; pc[1:0] ignored.
- Lookup is combinational from pc.
  - hit = valid && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = hit ? target : pc+4.
  - All sums are mod 2^32; 32'hFFFFFFFC + 4 = 0.
- Resolution is combinational:
  - res = ex_valid && ex_is_branch.
  - mispredict = res && (ex_taken != ex_pred_taken || (ex_taken && ex_target != ex_pred_target)).
  - flush = mispredict.
- next_pc priority:
  1. mispredict: ex_taken ? ex_target : ex_pc+4.
  2. pred_taken: pred_target.
  3. otherwise: pc+4.
- pc_write = ~stall | mispredict. Redirect overrides stall; flush is never lost.
- Training, on rising edge when res=1, index/tag taken from ex_pc:
  - Hit: ctr saturating +1 if ex_taken, -1 if not (11 and 00 saturate). target <= ex_target if ex_taken.
  - Miss and ex_taken: allocate/overwrite. valid=1, tag, target=ex_target, ctr=2'b10.
  - Miss and not taken: no allocation.
- Same-cycle lookup and training on the same index: lookup returns pre-update contents (no bypass). New contents are visible the next cycle.
- Counters:
  - branch_count +1 per res.
  - mispredict_count +1 per mispredict.
  - Both wrap at 2^32.
- ex_valid=0 or ex_is_branch=0: no table change, no counter change, flush=0.
- Reset (synchronous, takes priority over training in the same cycle):
  - All valid=0.
  - All ctr=RESET_CTR.
  - branch_count=0, mispredict_count=0.
- Outputs after reset:
  - pred_taken=0, pred_target=pc+4.
  - flush follows the ex_* inputs.
- Reset asserted mid-operation discards pending training. Tables are cleared at that edge.
- No state machine beyond the tables; all storage is flops; next_pc has no added latency.

Test Plan:
- Reset, then pc=32'h00000100, no resolution -> next_pc=32'h104, pred_taken=0, pc_write=1, counters 0.
- Resolve ex_pc=32'h100, taken, target=32'h40, ex_pred_taken=0 -> flush=1, next_pc=32'h40. Next cycle, pc=32'h100 -> pred_taken=1, pred_target=32'h40, branch_count=1, mispredict_count=1.
- Same entry resolved taken three times (ctr 10->11->11), then not-taken once -> ctr=10, prediction still taken. A second not-taken -> ctr=01, pc=32'h100 predicts 32'h104.
- Aliasing: allocate ex_pc=32'h100, then taken ex_pc=32'h140 (same index, different tag) -> entry replaced. pc=32'h100 -> miss, next_pc=32'h104.
- stall=1 with mispredict (ex_pc=32'h200, not taken, ex_pred_taken=1) -> pc_write=1, next_pc=32'h204, flush=1. stall=1 without resolution -> pc_write=0.
- Assert reset in the same cycle as a taken resolution -> no allocation. pc=ex_pc next cycle -> pred_taken=0, counters 0.

Source files
------------

// File: rtl/branch_predict_unit.sv
// Next-PC generation stage feeding the instruction fetch unit.
//
// The unit predicts the next fetch address from a direct-mapped branch target buffer (BTB).
// Each entry holds a valid bit, a tag, a target and a 2-bit saturating counter. It trains on
// branch resolutions from EX and, on a misprediction, redirects fetch and raises flush.
//
// Ports:
//   clock, reset          rising-edge clock; synchronous active-high reset
//   pc                    current fetch PC
//   stall                 hazard-unit request to hold fetch
//   next_pc, pc_write     address and load enable for the fetch PC register
//   pred_taken/target     prediction for pc, carried down the pipe with the instruction
//   ex_*                  branch resolution from EX
//   flush                 mispredict; squash IF/ID and ID/EX
//   branch_count          resolved branches since reset
//   mispredict_count      mispredictions since reset
module branch_predict_unit #(
  parameter int unsigned IDX_BITS  = 4,
  parameter logic [1:0]  RESET_CTR = 2'b01
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        stall,
  output logic [31:0] next_pc,
  output logic        pc_write,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic        ex_is_branch,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        flush,
  output logic [31:0] branch_count,
  output logic [31:0] mispredict_count
);

  localparam int unsigned Entries = 1 << IDX_BITS;
  localparam int unsigned TagW    = 30 - IDX_BITS;

  logic              valid_q  [Entries];
  logic [TagW-1:0]   tag_q    [Entries];
  logic [31:0]       target_q [Entries];
  logic [1:0]        ctr_q    [Entries];
  logic [31:0]       branch_count_q;
  logic [31:0]       mispredict_count_q;

  logic [IDX_BITS-1:0] lu_idx;
  logic [TagW-1:0]     lu_tag;
  logic                lu_hit;
  logic [31:0]         pc_plus4;

  logic [IDX_BITS-1:0] ex_idx;
  logic [TagW-1:0]     ex_tag;
  logic                ex_hit;
  logic                res;
  logic                mispredict;

  // Byte-offset bits never participate in lookup or training.
  logic unused_offset_bits;
  assign unused_offset_bits = ^{pc[1:0], ex_pc[1:0]};

  // Lookup reads the pre-update table: a same-cycle training write is not bypassed.
  always_comb begin
    lu_idx      = pc[IDX_BITS+1:2];
    lu_tag      = pc[31:IDX_BITS+2];
    pc_plus4    = pc + 32'd4;
    lu_hit      = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
    pred_taken  = lu_hit && ctr_q[lu_idx][1];
    pred_target = lu_hit ? target_q[lu_idx] : pc_plus4;
  end

  always_comb begin
    ex_idx     = ex_pc[IDX_BITS+1:2];
    ex_tag     = ex_pc[31:IDX_BITS+2];
    ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
    res        = ex_valid && ex_is_branch;
    mispredict = res && ((ex_taken != ex_pred_taken) ||
                         (ex_taken && (ex_target != ex_pred_target)));
    flush      = mispredict;
    // Redirect overrides stall so a flush is never dropped.
    pc_write   = ~stall | mispredict;
    if (mispredict) begin
      next_pc = ex_taken ? ex_target : (ex_pc + 32'd4);
    end else if (pred_taken) begin
      next_pc = pred_target;
    end else begin
      next_pc = pc_plus4;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < Entries; i++) begin
        valid_q[i] <= 1'b0;
        ctr_q[i]   <= RESET_CTR;
      end
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (res) begin
      branch_count_q <= branch_count_q + 32'd1;
      if (mispredict) begin
        mispredict_count_q <= mispredict_count_q + 32'd1;
      end
      if (ex_hit) begin
        if (ex_taken) begin
          target_q[ex_idx] <= ex_target;
          if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'b01;
        end else if (ctr_q[ex_idx] != 2'b00) begin
          ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'b01;
        end
      end else if (ex_taken) begin
        // Allocate, overwriting any aliasing entry, as weakly taken.
        valid_q[ex_idx]  <= 1'b1;
        tag_q[ex_idx]    <= ex_tag;
        target_q[ex_idx] <= ex_target;
        ctr_q[ex_idx]    <= 2'b10;
      end
    end
  end

  assign branch_count     = branch_count_q;
  assign mispredict_count = mispredict_count_q;

endmodule
